// File: rtl/cnt_seq_pkg.sv
// Shared constants for the counter sequencer: FSM state encodings and
// default configuration values.
package cnt_seq_pkg;

    // FSM state encodings (2-bit)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Default configuration: 8-bit odd counter 1, 3, ..., 255, 1, ...
    localparam int unsigned DEF_WIDTH      = 8;
    localparam int unsigned DEF_START_VAL  = 1;
    localparam int unsigned DEF_STEP_VAL   = 2;

endpackage : cnt_seq_pkg

// File: rtl/cnt_step_dp.sv
// Step-counter datapath: count register with load/increment/hold select,
// WIDTH+1 bit adder and terminal-count compare.
//   clk, reset   : clock, synchronous active-high reset
//   rst_val      : count value applied on reset
//   load         : load load_val into the count (has priority over inc)
//   load_val     : value to load
//   inc          : advance count by step
//   step, limit  : increment and highest legal count value
//   cnt          : current count (registered)
//   term_c       : next count would exceed limit or carry out (combinational)
module cnt_step_dp #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rst_val,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] cnt,
    output logic             term_c
);

    logic [WIDTH:0] nxt;

    // Extra bit keeps the carry so a wrap past 2**WIDTH-1 is always terminal.
    assign nxt    = {1'b0, cnt} + {1'b0, step};
    assign term_c = (nxt > {1'b0, limit});

    // Count register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= rst_val;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc) begin
            cnt <= nxt[WIDTH-1:0];
        end
    end

endmodule : cnt_step_dp

// File: rtl/cnt_seq_ctrl.sv
// Programmable counter sequencer: holds start/step/limit/reload config,
// sequences the step datapath through IDLE/RUN/PAUSE/DONE and signals
// terminal count.
//   clk, reset      : clock, synchronous active-high reset
//   cfg_valid_i     : config request, taken when cfg_ready_o is high
//   cfg_ready_o     : config can be accepted (IDLE or DONE)
//   cfg_start_i     : start/reload value
//   cfg_step_i      : increment per cycle
//   cfg_limit_i     : highest legal count value
//   cfg_reload_i    : 1 = auto-reload at terminal, 0 = one-shot
//   go_i            : start counting from IDLE/DONE
//   pause_i         : hold count while high
//   stop_i          : abort to IDLE
//   cnt_o           : current count
//   busy_o          : RUN or PAUSE
//   tc_o            : one-cycle terminal-count pulse
//   done_o          : one-shot sequence finished
module cnt_seq_ctrl
    import cnt_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned DEF_START = DEF_START_VAL,
    parameter int unsigned DEF_STEP  = DEF_STEP_VAL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [WIDTH-1:0] cfg_start_i,
    input  logic [WIDTH-1:0] cfg_step_i,
    input  logic [WIDTH-1:0] cfg_limit_i,
    input  logic             cfg_reload_i,
    input  logic             go_i,
    input  logic             pause_i,
    input  logic             stop_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             busy_o,
    output logic             tc_o,
    output logic             done_o
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] start_q, step_q, limit_q;
    logic             reload_q;
    logic             tc_q, tc_d;
    logic             busy_q, done_q, ready_q;

    logic             cfg_acc;
    logic             cfg_take;
    logic             dp_load;
    logic [WIDTH-1:0] dp_load_val;
    logic             dp_inc;
    logic             dp_term;

    assign cfg_acc = cfg_valid_i & ready_q;

    cnt_step_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk      (clk),
        .reset    (reset),
        .rst_val  (WIDTH'(DEF_START)),
        .load     (dp_load),
        .load_val (dp_load_val),
        .inc      (dp_inc),
        .step     (step_q),
        .limit    (limit_q),
        .cnt      (cnt_o),
        .term_c   (dp_term)
    );

    // State and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
            // Decoded from next state so the outputs line up with state_q.
            busy_q  <= (state_d == ST_RUN) || (state_d == ST_PAUSE);
            done_q  <= (state_d == ST_DONE);
            ready_q <= (state_d == ST_IDLE) || (state_d == ST_DONE);
        end
    end

    // Configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            start_q  <= WIDTH'(DEF_START);
            step_q   <= WIDTH'(DEF_STEP);
            limit_q  <= '1;
            reload_q <= 1'b1;
        end else if (cfg_take) begin
            start_q  <= cfg_start_i;
            step_q   <= cfg_step_i;
            limit_q  <= cfg_limit_i;
            reload_q <= cfg_reload_i;
        end
    end

    // Next-state and datapath control; priority stop > cfg > pause > go/terminal
    always_comb begin
        state_d     = state_q;
        cfg_take    = 1'b0;
        dp_load     = 1'b0;
        dp_load_val = start_q;
        dp_inc      = 1'b0;
        tc_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!stop_i) begin
                    if (cfg_acc) begin
                        cfg_take    = 1'b1;
                        dp_load     = 1'b1;
                        dp_load_val = cfg_start_i;
                    end else if (go_i) begin
                        state_d = ST_RUN;
                        dp_load = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (pause_i) begin
                    state_d = ST_PAUSE;
                end else if (!dp_term) begin
                    dp_inc = 1'b1;
                end else if (reload_q) begin
                    dp_load = 1'b1;
                    tc_d    = 1'b1;
                end else begin
                    state_d = ST_DONE;
                    tc_d    = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (!pause_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (cfg_acc) begin
                    state_d     = ST_IDLE;
                    cfg_take    = 1'b1;
                    dp_load     = 1'b1;
                    dp_load_val = cfg_start_i;
                end else if (go_i) begin
                    state_d = ST_RUN;
                    dp_load = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cfg_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign tc_o        = tc_q;

endmodule : cnt_seq_ctrl
